// File: rtl/apb_pixel_loader.sv
// -----------------------------------------------------------------------------
// apb_pixel_loader
//
// APB3 slave front end for the digit recognizer. It sits directly upstream of
// the pixel register file and the neuron calculator.
//
// It runs the APB handshake through a three-state FSM: IDLE, SETUP and ACCESS.
// The address, direction and write data are captured when the FSM enters
// SETUP, and every decode uses that captured copy. Bus changes made after
// that point have no effect on the transfer.
//
// Address map (Amba_Addr_Depth-bit word addresses):
//   0 .. PIXEL_WORDS-1    pixel words; writes become one-cycle mem_wr_en strobes
//   2^Amba_Addr_Depth-2   CTRL
//                           write: bit0 = start, bit1 = clear done
//                           read : {0, done, busy}
//   2^Amba_Addr_Depth-1   STATUS
//                           read : {0, result, done, busy}; writes ignored
//   anything else         writes dropped, reads return 0
//
// Pixel reads return 0 because there is no readback path to the pixel store.
// PIXEL_WORDS must not exceed 2^Amba_Addr_Depth-2, so the pixel range never
// overlaps CTRL or STATUS.
//
// Ports:
//   clk, rst     rising-edge clock; synchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA
//                APB3 request inputs
//   PRDATA       read data; nonzero only in the ACCESS cycle of a read
//   PREADY       1 in the ACCESS cycle (no wait states beyond SETUP)
//   mem_wr_en    one-cycle pixel write strobe
//   mem_addr     pixel write address; holds its value between strobes
//   mem_wdata    pixel write data; holds its value between strobes
//   start_calc   one-cycle start pulse to the neuron calculator
//   calc_done    calculator finished (pulse or level)
//   cat_result   classifier output, valid while calc_done is high
//   PSLVERR      only when APB_SLVERR_EN is defined; flags rejected transfers
//
// Build option:
//   APB_SLVERR_EN  adds the PSLVERR output. Without it, rejected transfers
//                  complete silently.
// -----------------------------------------------------------------------------
module apb_pixel_loader #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int PIXEL_WORDS     = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       mem_wr_en,
    output logic [Amba_Addr_Depth-1:0] mem_addr,
    output logic [Amba_Word-1:0]       mem_wdata,
    output logic                       start_calc,
    input  logic                       calc_done,
    input  logic                       cat_result
`ifdef APB_SLVERR_EN
   ,output logic                       PSLVERR
`endif
);

    // -------------------------------------------------------------------------
    // Address map constants
    // -------------------------------------------------------------------------
    localparam logic [Amba_Addr_Depth-1:0] ADDR_STATUS = '1;
    localparam logic [Amba_Addr_Depth-1:0] ADDR_CTRL   =
        {{(Amba_Addr_Depth-1){1'b1}}, 1'b0};

    // One bit wider than the address, so PIXEL_WORDS == 2^Amba_Addr_Depth
    // would still be representable.
    localparam logic [Amba_Addr_Depth:0]   PIX_LIMIT   =
        (Amba_Addr_Depth+1)'(PIXEL_WORDS);

    // -------------------------------------------------------------------------
    // APB state machine
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    apb_state_t state;
    apb_state_t state_next;
    logic       latch_en;

    // Transfer captured on entry to SETUP
    logic [Amba_Addr_Depth-1:0] lat_addr;
    logic                       lat_write;
    logic [Amba_Word-1:0]       lat_wdata;

    // Calculator bookkeeping
    logic busy;
    logic done;
    logic result;

    // NOTE: always_comb assigns every output a default before the case.
    // Any path that left a signal unassigned would infer a latch.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // PENABLE without a preceding setup phase is a protocol
                // error and is ignored here.
                if (PSEL && !PENABLE) begin
                    state_next = ST_SETUP;
                    latch_en   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (PSEL && PENABLE) begin
                    state_next = ST_ACCESS;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A new setup phase in the completing cycle chains the next
                // transfer without an IDLE cycle in between.
                if (PSEL && !PENABLE) begin
                    state_next = ST_SETUP;
                    latch_en   = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: every clocked process uses non-blocking assignments. All
    // registers then update together from pre-edge values, whatever order
    // the processes run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            // NOTE: the captured transfer is reset as well. Decode then
            // never works on X after reset, even though ACCESS cannot be
            // reached without a fresh capture.
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                lat_addr  <= PADDR;
                lat_write <= PWRITE;
                lat_wdata <= PWDATA;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode of the captured transfer
    // -------------------------------------------------------------------------
    logic in_access;
    logic acc_write;
    logic acc_read;
    logic is_pixel;
    logic is_ctrl;
    logic is_status;
    logic is_unmapped;
    logic pix_wr_ok;
    logic start_ok;
    logic clear_req;
    logic completion;

    assign in_access   = (state == ST_ACCESS);
    assign acc_write   = in_access &&  lat_write;
    assign acc_read    = in_access && !lat_write;

    assign is_pixel    = ({1'b0, lat_addr} < PIX_LIMIT);
    assign is_ctrl     = (lat_addr == ADDR_CTRL);
    assign is_status   = (lat_addr == ADDR_STATUS);
    assign is_unmapped = !(is_pixel || is_ctrl || is_status);

    // Busy is sampled before this cycle's completion is applied. A start
    // that lands in the same cycle as calc_done is therefore dropped.
    assign pix_wr_ok   = acc_write && is_pixel && !busy;
    assign start_ok    = acc_write && is_ctrl && lat_wdata[0] && !busy;
    assign clear_req   = acc_write && is_ctrl && lat_wdata[1];
    assign completion  = calc_done && busy;

    assign PREADY = in_access;

    always_comb begin
        PRDATA = '0;
        if (acc_read) begin
            if (is_ctrl) begin
                PRDATA = Amba_Word'({done, busy});
            end else if (is_status) begin
                PRDATA = Amba_Word'({result, done, busy});
            end
        end
    end

`ifdef APB_SLVERR_EN
    // Flag every transfer the block refuses to act on.
    always_comb begin
        PSLVERR = 1'b0;
        if (in_access) begin
            PSLVERR = is_unmapped
                   || (lat_write && is_pixel  && busy)
                   || (lat_write && is_ctrl   && lat_wdata[0] && busy)
                   || (lat_write && is_status);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Pixel strobe, start pulse and calculator status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            start_calc <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 1'b0;
        end else begin
            mem_wr_en  <= pix_wr_ok;
            start_calc <= start_ok;

            // Address and data move only with a strobe, so the memory
            // side sees stable values between writes.
            if (pix_wr_ok) begin
                mem_addr  <= lat_addr;
                mem_wdata <= lat_wdata;
            end

            // start_ok implies !busy while completion implies busy, so the
            // two branches never compete. The clear branch is last, so a
            // clear that coincides with completion leaves done set.
            if (completion) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= cat_result;
            end else if (start_ok) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (clear_req) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: doc/apb_pixel_loader.md
Name: apb_pixel_loader

Overview:
- APB3 slave front end that sits directly upstream of the recognizer's pixel register file and neuron calculator.
- Runs the APB handshake and decodes addresses.
- Turns host writes into single-cycle pixel-memory write strobes and a one-shot start pulse.
- Tracks busy/done, latches the classifier result and serves status readback on PRDATA.

Parameters:
- Amba_Word, 24, APB data width and pixel word width.
- Amba_Addr_Depth, 12, APB address width.
- PIXEL_WORDS, 1024, number of pixel words. Valid pixel addresses are 0..PIXEL_WORDS-1; must be <= 2^Amba_Addr_Depth-2.

Ports:
- clk  in  1  single rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction (1 = write).
- PADDR  in  Amba_Addr_Depth  APB address.
- PWDATA  in  Amba_Word  APB write data.
- PRDATA  out  Amba_Word  APB read data.
- PREADY  out  1  APB ready.
- mem_wr_en  out  1  pixel memory write strobe.
- mem_addr  out  Amba_Addr_Depth  pixel memory address.
- mem_wdata  out  Amba_Word  pixel memory write data.
- start_calc  out  1  one-cycle start pulse to the calculator.
- calc_done  in  1  calculator finished; may be a pulse or a level.
- cat_result  in  1  classifier output; valid while calc_done is high.

Behaviour:
- Address map:
  - Pixels at 0..PIXEL_WORDS-1.
  - CTRL at 2^Amba_Addr_Depth-2: write bit0 = start, bit1 = clear done; reads return {22'b0, done, busy}.
  - STATUS at 2^Amba_Addr_Depth-1: read {21'b0, result, done, busy}; writes ignored.
  - All other addresses: writes dropped, reads return 0.
- APB FSM:
  - IDLE -> SETUP when PSEL=1 and PENABLE=0. PADDR, PWRITE and PWDATA are latched here.
  - SETUP -> ACCESS on the next cycle when PSEL=1 and PENABLE=1. Otherwise return to IDLE, discarding the transfer.
  - ACCESS -> SETUP if PSEL=1 and PENABLE=0 (back-to-back). Otherwise -> IDLE.
  - PENABLE=1 seen in IDLE is a protocol error: ignored, FSM stays IDLE.
- Latched values only: PADDR/PWDATA changes between SETUP and ACCESS have no effect.
- PREADY is 1 in ACCESS and 0 elsewhere (zero wait states).
- PRDATA is driven from the latched address during ACCESS of a read, and is 0 at all other times.
- Pixel write, accepted in ACCESS while busy=0:
  - mem_wr_en=1 for exactly the following cycle.
  - In that cycle mem_addr = latched address and mem_wdata = latched data; both hold their values otherwise.
- Pixel write while busy=1: dropped. No strobe; the APB transfer still completes normally.
- CTRL write with bit0=1 while busy=0:
  - start_calc=1 for exactly the cycle after ACCESS; busy is set in the same cycle.
  - done is cleared in that same cycle.
- CTRL write with bit0=1 while busy=1: ignored.
- CTRL bit1=1: clears done. If bit0 and bit1 are both set, the start rule wins; done ends up 0 either way.
- calc_done sampled high while busy=1:
  - Next cycle: busy=0, done=1, result=cat_result.
  - calc_done while busy=0 is ignored.
- Simultaneous calc_done and CTRL start in the same cycle: completion is recorded first. The start is evaluated against the pre-completion busy=1 and is therefore dropped; the host must re-issue it.
- Reset values (all outputs and state): IDLE; PRDATA=0, PREADY=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, start_calc=0, busy=0, done=0, result=0.
- Reset mid-transfer or mid-calculation:
  - The transfer is abandoned and no strobe is issued.
  - busy/done/result return to 0.

Optional Feature:
- Macro APB_SLVERR_EN.
- When defined, adds output PSLVERR (1 bit, reset 0). It is 1 during ACCESS for any of:
  - an unmapped address;
  - a pixel write while busy;
  - a CTRL start while busy;
  - a STATUS write.
- When undefined, the port is absent, and all of these transfers complete silently with PSLVERR behaviour equivalent to 0.

Test Plan:
- Reset, then write PADDR=5, PWDATA=0xABCDEF -> exactly one cycle after ACCESS: mem_wr_en=1, mem_addr=5, mem_wdata=0xABCDEF; PREADY=1 only in ACCESS.
- Write CTRL=0x1 -> start_calc pulses once; STATUS reads 0x000001. Drive calc_done=1 with cat_result=1 -> STATUS reads 0x000006. Write CTRL=0x2 -> STATUS reads 0x000004.
- While busy, write pixel address 7 -> no mem_wr_en. With APB_SLVERR_EN, PSLVERR=1 in ACCESS.
- Back-to-back writes to addresses 0, 1, 2 with no IDLE between them -> three strobes, spaced 2 cycles apart, carrying the correct addresses and data.
- Read address 3000 (unmapped) -> PRDATA=0. With APB_SLVERR_EN, PSLVERR=1. PADDR changed during ACCESS -> decode still uses the SETUP value.
- Assert rst in the ACCESS cycle of a CTRL start while busy=0 -> no start_calc; all outputs return to their reset values the next cycle.
